// File: rtl/fc_sched.sv
// fc_sched -- binary fully-connected layer scheduler.
//
// Collects one binary frame of INPUT_NUM pixels as BEATS = INPUT_NUM/LANES
// beats, then streams OUTPUT_NUM weight rows from an external memory. A
// single shared XNOR-popcount unit scores each row. The optional argmax
// stage reports the winning neuron.
//
// Optional feature macro: FC_SCHED_ARGMAX_EN
//   defined   : running argmax, DONE state, class_valid/class_out/class_score
//   undefined : class outputs tied to 0, DONE skipped
//
// Ports:
//   clk, rst     : clock (rising edge) and synchronous active-high reset
//   valid_in     : input beat valid
//   ready_out    : beat accepted this cycle when valid_in is also 1 (FILL only)
//   pixel_in     : LANES binary pixels; lane i of beat k -> frame bit i*BEATS+k
//   wt_rd_en     : weight-row read strobe, wt_addr = neuron index
//   wt_data      : weight row, returned one cycle after wt_rd_en
//   score_valid  : one-cycle pulse per neuron score (score_idx, score_out)
//   class_valid  : one-cycle pulse with winning neuron (class_out, class_score)
module fc_sched #(
  parameter int INPUT_NUM  = 400,
  parameter int OUTPUT_NUM = 10,
  parameter int LANES      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [LANES-1:0]     pixel_in,
  output logic                 wt_rd_en,
  output logic [3:0]           wt_addr,
  input  logic [INPUT_NUM-1:0] wt_data,
  output logic                 score_valid,
  output logic [3:0]           score_idx,
  output logic [8:0]           score_out,
  output logic                 class_valid,
  output logic [3:0]           class_out,
  output logic [8:0]           class_score
);

  localparam int BEATS = INPUT_NUM / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {FILL, ISSUE, DRAIN, DONE} state_t;

  state_t               state, state_nx;
  logic [BW-1:0]        beat_cnt;
  logic [3:0]           issue_cnt;
  logic                 drain_cnt;
  logic                 accept;
  logic                 beat_last;
  logic                 issue_last;
  logic                 rd_d1;
  logic [3:0]           idx_d1;
  logic [INPUT_NUM-1:0] frame;
  logic [INPUT_NUM-1:0] xn;
  logic [8:0]           pop;

  assign ready_out  = (state == FILL);
  assign accept     = valid_in && ready_out;
  assign beat_last  = (beat_cnt == BW'(BEATS - 1));
  assign issue_last = (issue_cnt == 4'(OUTPUT_NUM - 1));
  assign wt_rd_en   = (state == ISSUE);
  // issue_cnt rests at 0 outside ISSUE, so the address is 0 whenever idle.
  assign wt_addr    = issue_cnt;

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:    if (accept && beat_last) state_nx = ISSUE;
      ISSUE:   if (issue_last) state_nx = DRAIN;
      // Two cycles: one for the memory read latency, one for the score register.
      DRAIN: begin
        if (drain_cnt) begin
`ifdef FC_SCHED_ARGMAX_EN
          state_nx = DONE;
`else
          state_nx = FILL;
`endif
        end
      end
      DONE:    state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      beat_cnt    <= '0;
      issue_cnt   <= '0;
      drain_cnt   <= 1'b0;
      rd_d1       <= 1'b0;
      idx_d1      <= '0;
      score_valid <= 1'b0;
      score_idx   <= '0;
      score_out   <= '0;
    end else begin
      state <= state_nx;
      if (accept) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      if (state == ISSUE) issue_cnt <= issue_last ? '0 : issue_cnt + 1'b1;
      if (state == DRAIN) drain_cnt <= ~drain_cnt;
      rd_d1       <= wt_rd_en;
      idx_d1      <= wt_addr;
      score_valid <= rd_d1;
      if (rd_d1) begin
        score_idx <= idx_d1;
        score_out <= pop;
      end
    end
  end

  // Frame buffer: written only by accepted beats, never cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        frame[i*BEATS + 32'(beat_cnt)] <= pixel_in[i];
      end
    end
  end

  // Shared XNOR-popcount over the row currently on wt_data.
  assign xn = ~(frame ^ wt_data);

  always_comb begin
    pop = '0;
    for (int unsigned j = 0; j < INPUT_NUM; j++) begin
      pop = pop + 9'(xn[j]);
    end
  end

`ifdef FC_SCHED_ARGMAX_EN
  logic [8:0] max_score;
  logic [3:0] max_idx;

  // Running max is rebuilt every frame; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_score   <= '0;
      max_idx     <= '0;
      class_out   <= '0;
      class_score <= '0;
    end else begin
      if (state == FILL) begin
        max_score <= '0;
        max_idx   <= '0;
      end else if (rd_d1 && (pop > max_score)) begin
        max_score <= pop;
        max_idx   <= idx_d1;
      end
      if ((state == DRAIN) && drain_cnt) begin
        class_out   <= max_idx;
        class_score <= max_score;
      end
    end
  end

  assign class_valid = (state == DONE);
`else
  assign class_valid = 1'b0;
  assign class_out   = '0;
  assign class_score = '0;
`endif

endmodule

// File: tb/tb_fc_sched.sv
module tb_fc_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         ready_out;
  logic [15:0]  pixel_in;
  logic         wt_rd_en;
  logic [3:0]   wt_addr;
  logic [399:0] wt_data;
  logic         score_valid;
  logic [3:0]   score_idx;
  logic [8:0]   score_out;
  logic         class_valid;
  logic [3:0]   class_out;
  logic [8:0]   class_score;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [15:0]  beats  [25];
  logic [399:0] rows   [16];
  int unsigned  exp_sc [10];
  int unsigned  exp_cls;
  int unsigned  exp_cs;

`ifdef FC_SCHED_ARGMAX_EN
  localparam bit ARGMAX = 1'b1;
`else
  localparam bit ARGMAX = 1'b0;
`endif

  fc_sched #(.INPUT_NUM(400), .OUTPUT_NUM(10), .LANES(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .pixel_in(pixel_in), .wt_rd_en(wt_rd_en), .wt_addr(wt_addr),
    .wt_data(wt_data), .score_valid(score_valid), .score_idx(score_idx),
    .score_out(score_out), .class_valid(class_valid), .class_out(class_out),
    .class_score(class_score)
  );

  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency.
  always @(posedge clk) if (wt_rd_en) wt_data <= rows[wt_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_vectors();
    for (int k = 0; k < 25; k++) beats[k] = '0;
    for (int r = 0; r < 16; r++) rows[r] = '0;
  endtask

  // Called at a negedge. Sends one frame, then observes cycles T+1..T+14.
  // abort_c > 0 pulses rst so it is sampled at the end of cycle T+abort_c.
  task automatic run_frame(input bit gaps, input bit hold, input int abort_c);
    int  w;
    bit  exp_sv;
    for (int k = 0; k < 25; k++) begin
      if (gaps && k > 0) begin
        valid_in = 1'b0;
        pixel_in = 16'($urandom);
        @(negedge clk);
      end
      w = 0;
      while (!ready_out && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!ready_out) check("ready_wait", {31'd0, ready_out}, 32'd1);
      valid_in = 1'b1;
      pixel_in = beats[k];
      @(negedge clk);
    end
    valid_in = hold;
    pixel_in = 16'($urandom);
    for (int c = 1; c <= 14; c++) begin
      if (abort_c > 0 && c > abort_c) begin
        check("abort_sv", {31'd0, score_valid}, 32'd0);
        check("abort_cv", {31'd0, class_valid}, 32'd0);
        check("abort_rdy", {31'd0, ready_out}, 32'd1);
        if (c == abort_c + 1) check("abort_score", {23'd0, score_out}, 32'd0);
      end else begin
        exp_sv = (c >= 3 && c <= 12);
        check("score_valid", {31'd0, score_valid}, {31'd0, exp_sv});
        if (exp_sv) begin
          check("score_idx", {28'd0, score_idx}, 32'(c - 3));
          check("score_out", {23'd0, score_out}, exp_sc[c-3]);
        end
        check("wt_rd_en", {31'd0, wt_rd_en}, {31'd0, (c >= 1 && c <= 10)});
        if (c <= 10) check("wt_addr", {28'd0, wt_addr}, 32'(c - 1));
        check("ready_out", {31'd0, ready_out}, {31'd0, (c >= (ARGMAX ? 14 : 13))});
        check("class_valid", {31'd0, class_valid}, {31'd0, (ARGMAX && c == 13)});
        if (ARGMAX && c >= 13) begin
          check("class_out", {28'd0, class_out}, exp_cls);
          check("class_score", {23'd0, class_score}, exp_cs);
        end
        if (c == 14) begin
          check("score_hold", {23'd0, score_out}, exp_sc[9]);
          check("idx_hold", {28'd0, score_idx}, 32'd9);
        end
      end
      if (hold && c == 11) valid_in = 1'b0;
      if (abort_c > 0 && c == abort_c) rst = 1'b1;
      if (abort_c > 0 && c == abort_c + 1) rst = 1'b0;
      @(negedge clk);
    end
    valid_in = 1'b0;
    rst = 1'b0;
  endtask

  task automatic setup_a();
    clear_vectors();
    for (int k = 0; k < 25; k++) beats[k] = 16'hFFFF;
    rows[3] = '1;
    for (int n = 0; n < 10; n++) exp_sc[n] = (n == 3) ? 400 : 0;
    exp_cls = 3; exp_cs = 400;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; pixel_in = '0;
    repeat (3) @(negedge clk);
    check("rst_wt_rd_en", {31'd0, wt_rd_en}, 32'd0);
    check("rst_wt_addr", {28'd0, wt_addr}, 32'd0);
    check("rst_score_valid", {31'd0, score_valid}, 32'd0);
    check("rst_score_idx", {28'd0, score_idx}, 32'd0);
    check("rst_score_out", {23'd0, score_out}, 32'd0);
    check("rst_class_valid", {31'd0, class_valid}, 32'd0);
    check("rst_class_out", {28'd0, class_out}, 32'd0);
    check("rst_class_score", {23'd0, class_score}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, ready_out}, 32'd1);

    // All-ones pixels, row 3 all ones.
    setup_a();
    run_frame(1'b0, 1'b0, 0);

    // Lane 0 beat 0 only; row 0 = bit 0.
    clear_vectors();
    beats[0] = 16'h0001;
    rows[0][0] = 1'b1;
    for (int n = 0; n < 10; n++) exp_sc[n] = (n == 0) ? 400 : 399;
    exp_cls = 0; exp_cs = 400;
    run_frame(1'b0, 1'b0, 0);

    // Lane 1 beat 1 lands at bit 26; row 1 = bit 1 mismatches twice.
    clear_vectors();
    beats[1] = 16'h0002;
    rows[0][26] = 1'b1;
    rows[1][1]  = 1'b1;
    for (int n = 0; n < 10; n++) exp_sc[n] = (n == 0) ? 400 : ((n == 1) ? 398 : 399);
    exp_cls = 0; exp_cs = 400;
    run_frame(1'b0, 1'b0, 0);

    // Rows 2 and 7 tie at the maximum; others have n+1 ones.
    clear_vectors();
    for (int n = 0; n < 10; n++) begin
      if (n != 2 && n != 7)
        for (int b = 0; b <= n; b++) rows[n][b] = 1'b1;
      exp_sc[n] = (n == 2 || n == 7) ? 400 : 400 - (n + 1);
    end
    exp_cls = 2; exp_cs = 400;
    run_frame(1'b0, 1'b0, 0);

    // Gapped valid_in, valid_in held high while scoring.
    setup_a();
    run_frame(1'b1, 1'b1, 0);
    // Next frame must start clean.
    setup_a();
    run_frame(1'b0, 1'b0, 0);

    // Reset right after score 4, then a fresh frame.
    setup_a();
    run_frame(1'b0, 1'b0, 7);
    setup_a();
    run_frame(1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_sched.md
FC_SCHED -- requirements
Module: fc_sched

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 400, number of binary inputs per frame.
REQ-002 SHALL have parameter OUTPUT_NUM, default 10, number of output neurons.
REQ-003 SHALL have parameter LANES, default 16, pixels per input beat; BEATS = INPUT_NUM/LANES (25) SHALL be a derived localparam.
REQ-004 SHALL have port clk  input  1  the single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port valid_in  input  1  input beat valid.
REQ-007 SHALL have port ready_out  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port pixel_in  input  LANES  binary pixels of one beat; bit i is lane i.
REQ-009 SHALL have port wt_rd_en  output  1  weight-row read strobe.
REQ-010 SHALL have port wt_addr  output  4  weight row (neuron) index.
REQ-011 SHALL have port wt_data  input  INPUT_NUM  weight row returned exactly one cycle after wt_rd_en.
REQ-012 SHALL have port score_valid  output  1  one-cycle pulse per neuron score.
REQ-013 SHALL have port score_idx  output  4  neuron index of score_out.
REQ-014 SHALL have port score_out  output  9  XNOR-popcount score, 0..INPUT_NUM.
REQ-015 SHALL have port class_valid  output  1  one-cycle pulse, frame classification ready.
REQ-016 SHALL have port class_out  output  4  winning neuron index.
REQ-017 SHALL have port class_score  output  9  winning score.

Function
REQ-018 SHALL implement states FILL, ISSUE, DRAIN, DONE; FILL is the reset state.
REQ-019 In FILL, ready_out SHALL be 1; a beat transfers only when valid_in && ready_out; other cycles are ignored.
REQ-020 Beat k (0..BEATS-1) lane i SHALL be stored at frame bit i*BEATS + k.
REQ-021 The beat counter SHALL wrap from BEATS-1 to 0; after accepting beat BEATS-1, FILL -> ISSUE.
REQ-022 In ISSUE, wt_rd_en SHALL be 1 for OUTPUT_NUM consecutive cycles with wt_addr = 0,1,...,OUTPUT_NUM-1; then ISSUE -> DRAIN.
REQ-023 A single shared XNOR-popcount unit SHALL compute score = count of positions where frame bit == wt_data bit, registered; no per-neuron duplicate.
REQ-024 If the last beat is accepted in cycle T, score for neuron n SHALL be valid in cycle T+3+n, with score_idx = n.
REQ-025 Outside ISSUE/DRAIN/DONE, score_valid, class_valid, wt_rd_en SHALL be 0; ready_out SHALL be 0 in ISSUE, DRAIN, DONE.
REQ-026 Popcount width SHALL be 9 bits unsigned; no saturation needed (max 400).
REQ-027 Argmax SHALL keep a running maximum; replace only on strictly greater score, so ties resolve to the lowest index.
REQ-028 DRAIN SHALL last until the last score is emitted; DONE SHALL assert class_valid for one cycle (T+13 at defaults); next cycle state SHALL be FILL (ready_out = 1 at T+14).
REQ-029 class_out/class_score SHALL hold their values until the next class_valid; score_out/score_idx SHALL hold the last score.
REQ-030 Frame buffer SHALL not be modified outside FILL.

Reset
REQ-031 On rst = 1 at a clock edge: state = FILL, beat counter = 0, issue/drain counters = 0, running max = 0 with index 0.
REQ-032 Reset values: ready_out 1 after reset release is sampled, wt_rd_en 0, wt_addr 0, score_valid 0, score_idx 0, score_out 0, class_valid 0, class_out 0, class_score 0.
REQ-033 Reset mid-frame or mid-issue SHALL abort the frame: no further score_valid/class_valid from it; buffer contents need not be cleared.

Configuration
REQ-034 Macro FC_SCHED_ARGMAX_EN defined: argmax logic, DONE state and class outputs per REQ-027..029.
REQ-035 FC_SCHED_ARGMAX_EN undefined: no argmax logic; class_valid, class_out, class_score tied 0; DONE skipped, FILL entered the cycle after the last score (ready_out = 1 at T+13).

Verification
REQ-036 All-ones pixels, row 3 all ones, other rows all zeros -> scores 0,0,0,400,0,...; class_out 3, class_score 400 at T+13.
REQ-037 Only lane 0 beat 0 = 1, row 0 = bit 0 only, row 1 all zeros -> score[0] = 400, score[1] = 399, class_out 0.
REQ-038 Rows 2 and 7 identical and maximal -> class_out 2.
REQ-039 valid_in toggled every other cycle, plus valid_in held high during ISSUE/DRAIN -> same results as gap-free; extra beats ignored, next frame starts clean.
REQ-040 rst pulsed in cycle after score 4 -> no score 5..9, no class_valid; fresh frame afterwards yields correct scores.
REQ-041 Build without FC_SCHED_ARGMAX_EN -> class_valid never 1; ready_out 1 at T+13.
